// File: rtl/sensor_pulse_gen.sv
// sensor_pulse_gen: generates active-low nFork / nCrank sensor pulse trains
// from programmed periods (in clock cycles). Each channel emits a falling edge
// every P cycles with a low phase of PULSE_WIDTH cycles. New periods go into a
// shadow register on load and are adopted only at a period boundary, so a
// period in progress is never shortened or stretched.
//
// Ports:
//   Clock, nReset           system clock, asynchronous active-low reset
//   enable                  channels run while 1; stop at next boundary when 0
//   load                    strobe capturing both period inputs into shadows
//   fork_period_in          fork period request (0 = off)
//   crank_period_in         crank period request (0 = off)
//   nFork, nCrank           registered active-low pulse outputs
//   update_pending          a shadow period is still waiting to be adopted
//   fork_pulses             wrapping count of nFork falling edges
//   crank_pulses            wrapping count of nCrank falling edges
//
// Channel FSM:
//   state | meaning
//   IDLE  | output high, waiting for enable and a non-zero active period
//   LOW   | low phase, cnt = 0 .. PULSE_WIDTH-1
//   HIGH  | high phase, cnt = PULSE_WIDTH .. P-1, boundary at cnt = P-1

module sensor_pulse_ch #(
  parameter int PULSE_WIDTH = 64,
  parameter int MIN_PERIOD  = 128,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  output logic             n_pulse,
  output logic [CNT_W-1:0] pulses,
  output logic             pending_next
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] clamped;
  logic [CNT_W-1:0] next_period;
  logic             pending;
  logic             boundary;
  logic             adopt;

  always_comb begin
    if (period_in == '0)
      clamped = '0;
    else if (period_in < MIN_P)
      clamped = MIN_P;
    else
      clamped = period_in;
  end

  // A zero active period can only reach HIGH if a zero shadow was adopted on
  // the same edge that launched from IDLE; end that period right away.
  assign boundary     = (state == HIGH) && ((active == '0) || (cnt == active - ONE));
  assign adopt        = pending && ((state == IDLE) || boundary);
  // load wins over adoption: the boundary takes the old shadow, flag stays set.
  assign pending_next = load || (pending && !adopt);
  assign next_period  = adopt ? shadow : active;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      cnt     <= '0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      n_pulse <= 1'b1;
      pulses  <= '0;
    end else begin
      if (load)
        shadow <= clamped;
      pending <= pending_next;
      if (adopt)
        active <= shadow;

      case (state)
        IDLE: begin
          n_pulse <= 1'b1;
          // launch decision uses the active period from before this edge
          if (enable && (active != '0)) begin
            state   <= LOW;
            n_pulse <= 1'b0;
            cnt     <= '0;
            pulses  <= pulses + ONE;
          end
        end
        LOW: begin
          cnt <= cnt + ONE;
          if (cnt == LOW_LAST) begin
            state   <= HIGH;
            n_pulse <= 1'b1;
          end
        end
        HIGH: begin
          if (boundary) begin
            cnt <= '0;
            if (!enable || (next_period == '0)) begin
              state <= IDLE;
            end else begin
              state   <= LOW;
              n_pulse <= 1'b0;
              pulses  <= pulses + ONE;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state   <= IDLE;
          n_pulse <= 1'b1;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

module sensor_pulse_gen #(
  parameter int PULSE_WIDTH = 64,
  parameter int MIN_PERIOD  = 128,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] fork_period_in,
  input  logic [CNT_W-1:0] crank_period_in,
  output logic             nFork,
  output logic             nCrank,
  output logic             update_pending,
  output logic [CNT_W-1:0] fork_pulses,
  output logic [CNT_W-1:0] crank_pulses
);

  logic fork_pending_next;
  logic crank_pending_next;

  sensor_pulse_ch #(
    .PULSE_WIDTH (PULSE_WIDTH),
    .MIN_PERIOD  (MIN_PERIOD),
    .CNT_W       (CNT_W)
  ) u_fork (
    .Clock        (Clock),
    .nReset       (nReset),
    .enable       (enable),
    .load         (load),
    .period_in    (fork_period_in),
    .n_pulse      (nFork),
    .pulses       (fork_pulses),
    .pending_next (fork_pending_next)
  );

  sensor_pulse_ch #(
    .PULSE_WIDTH (PULSE_WIDTH),
    .MIN_PERIOD  (MIN_PERIOD),
    .CNT_W       (CNT_W)
  ) u_crank (
    .Clock        (Clock),
    .nReset       (nReset),
    .enable       (enable),
    .load         (load),
    .period_in    (crank_period_in),
    .n_pulse      (nCrank),
    .pulses       (crank_pulses),
    .pending_next (crank_pending_next)
  );

  // Registered from the channels' next-state flags so it tracks them exactly.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)
      update_pending <= 1'b0;
    else
      update_pending <= fork_pending_next || crank_pending_next;
  end

endmodule
